// File: rtl/pulse_conditioner_if.sv
// rtl/pulse_conditioner_if.sv - control, pin and status bundle for the pulse conditioner
// The master side drives pins and controls; the slave side (the conditioner) returns level, strobe and status.
interface pulse_conditioner_if #(
   parameter int NUM_INPUTS  = 12,
   parameter int COUNT_WIDTH = 32
);
   logic                   enable;
   logic                   clear_glitch;
   logic [NUM_INPUTS-1:0]  pulse_in;
   logic [NUM_INPUTS-1:0]  level_out;
   logic [NUM_INPUTS-1:0]  pulse_out;
   logic [NUM_INPUTS-1:0]  glitch;
   logic [COUNT_WIDTH-1:0] event_count;

   modport master (
      output enable, clear_glitch, pulse_in,
      input  level_out, pulse_out, glitch, event_count
   );

   modport slave (
      input  enable, clear_glitch, pulse_in,
      output level_out, pulse_out, glitch, event_count
   );
endinterface

// File: rtl/pulse_conditioner.sv
// rtl/pulse_conditioner.sv - per-channel pin synchroniser, width filter and dead-time enforcer
// Each channel emits a clean level and a one-cycle accept strobe; strobes feed a global event counter.
module pulse_conditioner #(
   parameter int NUM_INPUTS  = 12,
   parameter int SYNC_STAGES = 2,
   parameter int MIN_WIDTH   = 4,
   parameter int HOLDOFF     = 8,
   parameter int COUNT_WIDTH = 32
) (
   input  logic          clk,
   input  logic          reset_n,
   pulse_conditioner_if.slave bus
);

   localparam int MAXC = (MIN_WIDTH > HOLDOFF) ? MIN_WIDTH : HOLDOFF;
   localparam int CW   = (MAXC < 2) ? 1 : $clog2(MAXC);
   localparam logic [CW-1:0] MW_LAST = CW'(MIN_WIDTH - 1);
   localparam logic [CW-1:0] HO_LAST = CW'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

   typedef enum logic [1:0] {
      S_IDLE,
      S_QUALIFY,
      S_ACTIVE,
      S_HOLDOFF
   } state_t;

   logic [NUM_INPUTS-1:0]  r_sync [SYNC_STAGES];
   logic [NUM_INPUTS-1:0]  w_s;
   state_t                 r_state [NUM_INPUTS];
   logic [CW-1:0]          r_cnt [NUM_INPUTS];
   logic [NUM_INPUTS-1:0]  r_level;
   logic [NUM_INPUTS-1:0]  r_pulse;
   logic [NUM_INPUTS-1:0]  r_glitch;
   logic [COUNT_WIDTH-1:0] r_count;

   assign w_s             = r_sync[SYNC_STAGES-1];
   assign bus.level_out   = r_level;
   assign bus.pulse_out   = r_pulse;
   assign bus.glitch      = r_glitch;
   assign bus.event_count = r_count;

   // Synchronisers keep running regardless of enable so re-enable sees the true pin level.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '0;
      end else begin
         r_sync[0] <= bus.pulse_in;
         for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_INPUTS; i++) begin
            r_state[i] <= S_IDLE;
            r_cnt[i]   <= '0;
         end
         r_level  <= '0;
         r_pulse  <= '0;
         r_glitch <= '0;
      end else begin
         for (int i = 0; i < NUM_INPUTS; i++) begin
            r_pulse[i] <= 1'b0;
            // A glitch set later in this iteration overrides the clear.
            if (bus.clear_glitch) r_glitch[i] <= 1'b0;
            if (!bus.enable) begin
               r_state[i] <= S_IDLE;
               r_cnt[i]   <= '0;
               r_level[i] <= 1'b0;
            end else begin
               case (r_state[i])
                  S_IDLE: begin
                     if (w_s[i]) begin
                        if (MIN_WIDTH == 1) begin
                           r_state[i] <= S_ACTIVE;
                           r_level[i] <= 1'b1;
                           r_pulse[i] <= 1'b1;
                        end else begin
                           r_state[i] <= S_QUALIFY;
                           r_cnt[i]   <= CW'(1);
                        end
                     end
                  end
                  S_QUALIFY: begin
                     if (!w_s[i]) begin
                        r_state[i]  <= S_IDLE;
                        r_cnt[i]    <= '0;
                        r_glitch[i] <= 1'b1;
                     end else if (r_cnt[i] == MW_LAST) begin
                        r_state[i] <= S_ACTIVE;
                        r_level[i] <= 1'b1;
                        r_pulse[i] <= 1'b1;
                     end else begin
                        r_cnt[i] <= r_cnt[i] + 1'b1;
                     end
                  end
                  S_ACTIVE: begin
                     if (!w_s[i]) begin
                        r_level[i] <= 1'b0;
                        r_cnt[i]   <= '0;
                        r_state[i] <= (HOLDOFF == 0) ? S_IDLE : S_HOLDOFF;
                     end
                  end
                  S_HOLDOFF: begin
                     if (r_cnt[i] == HO_LAST) begin
                        r_state[i] <= S_IDLE;
                        r_cnt[i]   <= '0;
                     end else begin
                        r_cnt[i] <= r_cnt[i] + 1'b1;
                     end
                  end
                  default: begin
                     r_state[i] <= S_IDLE;
                     r_cnt[i]   <= '0;
                  end
               endcase
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_count <= '0;
      end else begin
         r_count <= r_count + COUNT_WIDTH'($countones(r_pulse));
      end
   end

endmodule
